// File: rtl/feedback_filter.sv
// feedback_filter: synchronizes and debounces an 8-bit asynchronous status
// vector, then presents it on feedbak_sig with a snapshot/freeze handshake.
// Optional macro FEEDBACK_STICKY_EN: bits [5:2] of feedbak_sig latch high in
// IDLE and only reload from the filtered value on a HOLD->IDLE transition.
module feedback_filter #(
    parameter int SAMPLE_DIV = 1000,
    parameter int STABLE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] raw_sig,
    input  logic       snap_req,
    output logic       snap_ack,
    output logic [7:0] feedbak_sig,
    output logic       sig_changed
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_HOLD  = 1'b1;
    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [3:0]  RUN_LAST = 4'(STABLE_CNT - 1);

    logic [7:0]  sync1_q, sync1_d;
    logic [7:0]  sync2_q, sync2_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tick;
    logic [7:0]  filt_q, filt_d;
    logic [3:0]  run_q [8];
    logic [3:0]  run_d [8];
    logic        chg_q, chg_d;
    logic [0:0]  state_q, state_d;
    logic        ack_q, ack_d;
    logic [7:0]  fb_q, fb_d;

    // Two-flop synchronizer: raw_sig is never used before the second stage.
    always_comb begin
        sync1_d = raw_sig;
        sync2_d = sync1_q;
    end

    // Sample-tick divider; with SAMPLE_DIV=1 the tick is high every cycle.
    assign tick = (cnt_q == DIV_LAST);
    always_comb begin
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    // Per-bit debounce: a bit flips only after STABLE_CNT consecutive differing
    // ticks; any agreeing tick in between clears the run (glitch rejection).
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 8; i++) begin
            run_d[i] = run_q[i];
            if (tick) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (run_q[i] == RUN_LAST) begin
                        filt_d[i] = sync2_q[i];
                        run_d[i]  = 4'd0;
                    end else begin
                        run_d[i] = run_q[i] + 4'd1;
                    end
                end else begin
                    run_d[i] = 4'd0;
                end
            end
        end
        // One pulse no matter how many bits flip together.
        chg_d = |(filt_d ^ filt_q);
    end

    // Snapshot FSM: IDLE tracks the filtered vector, HOLD freezes the output.
    always_comb begin
        state_d = state_q;
        fb_d    = fb_q;
        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    state_d = ST_HOLD;
                end else begin
`ifdef FEEDBACK_STICKY_EN
                    fb_d      = filt_q;
                    fb_d[5:2] = filt_q[5:2] | fb_q[5:2];
`else
                    fb_d = filt_q;
`endif
                end
            end
            default: begin
                if (!snap_req) begin
                    state_d = ST_IDLE;
                    // Leaving HOLD reloads every bit, including sticky ones.
                    fb_d    = filt_q;
                end
            end
        endcase
        ack_d = (state_d == ST_HOLD);
    end

    // All state registers; reset clears everything and wins over any HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 8'd0;
            sync2_q <= 8'd0;
            cnt_q   <= 16'd0;
            filt_q  <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                run_q[i] <= 4'd0;
            end
            chg_q   <= 1'b0;
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            fb_q    <= 8'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            for (int i = 0; i < 8; i++) begin
                run_q[i] <= run_d[i];
            end
            chg_q   <= chg_d;
            state_q <= state_d;
            ack_q   <= ack_d;
            fb_q    <= fb_d;
        end
    end

    assign snap_ack    = ack_q;
    assign feedbak_sig = fb_q;
    assign sig_changed = chg_q;

endmodule

// File: tb/tb_feedback_filter.sv
// Directed testbench for feedback_filter with SAMPLE_DIV=4, STABLE_CNT=4.
module tb_feedback_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw_sig;
    logic       snap_req;
    logic       snap_ack;
    logic [7:0] feedbak_sig;
    logic       sig_changed;

    int total = 0;
    int bad   = 0;
    int chg_cnt = 0;
    int base;
    int hold_bad;

    feedback_filter #(.SAMPLE_DIV(4), .STABLE_CNT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_sig     (raw_sig),
        .snap_req    (snap_req),
        .snap_ack    (snap_ack),
        .feedbak_sig (feedbak_sig),
        .sig_changed (sig_changed)
    );

    always #5 clk = ~clk;

    // Count sig_changed pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (sig_changed) chg_cnt <= chg_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for feedbak_sig to reach a value; a timeout shows up in the check.
    task automatic wait_fb(input logic [7:0] v, input int limit);
        for (int i = 0; i < limit && feedbak_sig !== v; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; raw_sig = 8'h00; snap_req = 1'b0;
        cyc(3);
        check("rst_fb", feedbak_sig, 8'h00);
        check("rst_ack", snap_ack, 1'b0);
        check("rst_chg", sig_changed, 1'b0);
        rst = 1'b0;
        cyc(2);

        // Single stable bit propagates with one change pulse.
        base = chg_cnt;
        raw_sig = 8'h04;
        wait_fb(8'h04, 40);
        check("bit2_set", feedbak_sig, 8'h04);
        check("bit2_ack", snap_ack, 1'b0);
        cyc(3);
        check("bit2_pulses", chg_cnt - base, 1);

        raw_sig = 8'h00;
        wait_fb(8'h00, 40);
        check("bit2_clr", feedbak_sig, 8'h00);
        cyc(3);

        // Three-tick glitch on bit 3 is rejected.
        base = chg_cnt;
        raw_sig = 8'h08;
        cyc(12);
        raw_sig = 8'h00;
        cyc(40);
        check("glitch_fb", feedbak_sig, 8'h00);
        check("glitch_pulses", chg_cnt - base, 0);

        // Two bits changing together give one pulse.
        base = chg_cnt;
        raw_sig = 8'h24;
        wait_fb(8'h24, 40);
        check("dual_fb", feedbak_sig, 8'h24);
        cyc(3);
        check("dual_pulses", chg_cnt - base, 1);

        // Freeze during HOLD while filtering keeps running.
        raw_sig = 8'h10;
        wait_fb(8'h10, 40);
        check("pre_hold_fb", feedbak_sig, 8'h10);
        cyc(3);
        snap_req = 1'b1;
        cyc(1);
        check("hold_ack", snap_ack, 1'b1);
        base = chg_cnt;
        raw_sig = 8'h00;
        hold_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (feedbak_sig !== 8'h10 || snap_ack !== 1'b1) hold_bad++;
        end
        check("hold_frozen", hold_bad, 0);
        check("hold_pulses", chg_cnt - base, 1);
        snap_req = 1'b0;
        cyc(1);
        check("release_ack", snap_ack, 1'b0);
        check("release_fb", feedbak_sig, 8'h00);

        // Reset during HOLD, then HOLD again straight after release.
        raw_sig = 8'h3C;
        wait_fb(8'h3C, 40);
        check("pre_rst_fb", feedbak_sig, 8'h3C);
        snap_req = 1'b1;
        cyc(2);
        check("pre_rst_ack", snap_ack, 1'b1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_hold_ack", snap_ack, 1'b0);
        check("rst_hold_fb", feedbak_sig, 8'h00);
        cyc(1);
        check("rehold_ack", snap_ack, 1'b1);
        cyc(30);
        check("rehold_fb", feedbak_sig, 8'h00);
        snap_req = 1'b0;
        cyc(1);
        check("rehold_release_fb", feedbak_sig, 8'h3C);

        // Bit 4 pulse: sticky build holds it until a snapshot handshake.
        raw_sig = 8'h00;
        snap_req = 1'b1;
        cyc(30);
        snap_req = 1'b0;
        cyc(2);
        check("sticky_pre_fb", feedbak_sig, 8'h00);
        raw_sig = 8'h10;
        cyc(24);
        check("sticky_set_fb", feedbak_sig, 8'h10);
        raw_sig = 8'h00;
        cyc(30);
`ifdef FEEDBACK_STICKY_EN
        check("sticky_hold_fb", feedbak_sig, 8'h10);
`else
        check("sticky_hold_fb", feedbak_sig, 8'h00);
`endif
        snap_req = 1'b1;
        cyc(2);
        snap_req = 1'b0;
        cyc(2);
        check("sticky_release_fb", feedbak_sig, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/feedback_filter.md
FEEDBACK_FILTER -- requirements
Module: feedback_filter

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1000, the number of clk cycles per sample tick (range 1..65535).
REQ-002 SHALL have parameter STABLE_CNT, default 4, the consecutive differing ticks needed to accept a new bit value (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port raw_sig, input, 8, asynchronous kitchen status: [2] player_ready, [3] player_hasitem, [4] target_ready, [5] target_hasitem, [1:0],[7:6] spare status.
REQ-006 SHALL have port snap_req, input, 1, the consumer's request to freeze feedbak_sig for evaluation.
REQ-007 SHALL have port snap_ack, output, 1, high while feedbak_sig is frozen and valid for the consumer.
REQ-008 SHALL have port feedbak_sig, output, 8, the filtered status vector consumed by the script jump unit.
REQ-009 SHALL have port sig_changed, output, 1, a one-cycle pulse when any filtered bit changes.

Function
REQ-010 SHALL pass raw_sig through a 2-flop synchronizer before any other use.
REQ-011 SHALL count sample ticks with a counter 0..SAMPLE_DIV-1 that raises a one-cycle tick on wrap; with SAMPLE_DIV=1 the tick SHALL be high every cycle.
REQ-012 SHALL keep one filtered bit and one 4-bit run counter per input bit.
REQ-013 On a tick where the synced bit differs from the filtered bit, the run counter SHALL increment; at the STABLE_CNT-th consecutive differing tick, the filtered bit SHALL take the synced value and the counter SHALL clear.
REQ-014 On a tick where the synced bit equals the filtered bit, the run counter SHALL clear (glitch rejection).
REQ-015 sig_changed SHALL pulse high for exactly one cycle, the cycle after any filtered bit updates; simultaneous bit updates SHALL produce a single pulse.
REQ-016 The control FSM SHALL have states IDLE and HOLD.
REQ-017 In IDLE, feedbak_sig SHALL be registered from the filtered vector every cycle (1-cycle latency), and snap_ack SHALL be 0.
REQ-018 IDLE->HOLD when snap_req=1; feedbak_sig SHALL be frozen from that edge, and snap_ack SHALL be 1 from the next cycle.
REQ-019 In HOLD, feedbak_sig SHALL stay constant; filtering and sig_changed SHALL continue running.
REQ-020 HOLD->IDLE when snap_req=0; snap_ack SHALL drop the following cycle, and feedbak_sig SHALL resume tracking the same cycle.
REQ-021 A filtered change during HOLD SHALL appear on feedbak_sig one cycle after returning to IDLE.
REQ-022 snap_req held high continuously SHALL keep HOLD indefinitely with no timeout.

Reset
REQ-023 On rst=1 at a clk edge, the synchronizer, filtered bits, run counters, tick counter and feedbak_sig SHALL clear to 0, snap_ack and sig_changed to 0, and the FSM to IDLE.
REQ-024 Reset SHALL take priority over every other event, including a HOLD in progress; snap_req high after reset release SHALL enter HOLD normally.

Configuration
REQ-025 Macro FEEDBACK_STICKY_EN SHALL select sticky latching of bits [5:2].
REQ-026 With FEEDBACK_STICKY_EN defined, in IDLE a bit in feedbak_sig[5:2] that becomes 1 SHALL stay 1 even if the filtered bit falls, until a HOLD->IDLE transition, when it reloads from the filtered value.
REQ-027 Without FEEDBACK_STICKY_EN, feedbak_sig SHALL follow REQ-017 for all bits, and no sticky registers SHALL exist.

Verification (bench: SAMPLE_DIV=4, STABLE_CNT=4)
REQ-028 raw_sig=0x04 held after reset -> feedbak_sig[2]=1 within 2+16+1 cycles (plus tick phase); sig_changed pulses once.
REQ-029 raw_sig[3] pulsed high for 3 ticks, then low -> feedbak_sig stays 0x00; sig_changed never pulses.
REQ-030 snap_req=1 with feedbak_sig=0x10, then raw_sig=0x00 held for 40 cycles -> feedbak_sig stays 0x10 while snap_ack=1; after snap_req=0, feedbak_sig=0x00 within 2 cycles.
REQ-031 rst=1 for one cycle during HOLD with feedbak_sig=0x3C -> next cycle snap_ack=0, feedbak_sig=0x00, FSM in IDLE.
REQ-032 FEEDBACK_STICKY_EN defined; raw_sig[4] high for 24 cycles, then low -> feedbak_sig[4] stays 1 until a snap_req 1->0 handshake, then reads 0.
REQ-033 raw_sig 0x00->0x24 in one cycle -> bits 2 and 5 update in the same cycle, with exactly one sig_changed pulse.
